// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller: FSM states,
// instruction-class opcodes and ALU operation codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  // Funct[4:1] command encodings for data-processing instructions
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_CMP = 4'b1010;

endpackage

// File: rtl/mc_decoder_alu.sv
// Combinational ALU decoder: maps the DP command field to an ALU code, flag
// write enables and the no-writeback qualifier; also flags unmapped commands.
module alu_decoder
  import mc_pkg::*;
#(
  parameter int ALU_W   = 3,
  parameter int EXT_OPS = 1
) (
  input  logic             aluop,
  input  logic [4:0]       funct,
  output logic [ALU_W-1:0] alucontrol,
  output logic [1:0]       flagw,
  output logic             nowrite,
  output logic             unmapped
);

  logic [2:0] code;
  logic       mapped;
  logic       cmp;

  always_comb begin
    code   = ALU_ADD;
    mapped = 1'b1;
    cmp    = 1'b0;
    case (funct[4:1])
      CMD_ADD: code = ALU_ADD;
      CMD_SUB: code = ALU_SUB;
      CMD_AND: code = ALU_AND;
      CMD_ORR: code = ALU_ORR;
      CMD_EOR: if (EXT_OPS != 0) code = ALU_EOR; else mapped = 1'b0;
      CMD_MOV: if (EXT_OPS != 0) code = ALU_MOV; else mapped = 1'b0;
      // CMP reuses the subtractor but suppresses the register write
      CMD_CMP: begin
        if (EXT_OPS != 0) begin
          code = ALU_SUB;
          cmp  = 1'b1;
        end else begin
          mapped = 1'b0;
        end
      end
      default: mapped = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = ALU_W'(ALU_ADD);
    flagw      = 2'b00;
    nowrite    = 1'b0;
    if (aluop) begin
      alucontrol = ALU_W'(code);
      flagw[1]   = funct[0] | cmp;
      flagw[0]   = flagw[1] & ((code == ALU_ADD) | (code == ALU_SUB));
      nowrite    = cmp;
    end
  end

  assign unmapped = ~mapped;

endmodule

// File: rtl/mc_decoder.sv
// Multicycle controller: Moore FSM sequencing fetch/decode/execute plus
// instruction-field decode for immediate, register and ALU selects.
module mc_decoder
  import mc_pkg::*;
#(
  parameter int ALU_W   = 3,
  parameter int EXT_OPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  output logic             IRWrite,
  output logic             NextPC,
  output logic             RegW,
  output logic             MemW,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic [ALU_W-1:0] ALUControl,
  output logic [1:0]       FlagW,
  output logic             PCS,
  output logic             NoWrite,
  output logic             Undef
);

  if (!(ALU_W == 2 || ALU_W == 3) || (EXT_OPS != 0 && ALU_W < 3)) begin : g_param_check
    $error("mc_decoder: ALU_W must be 2 or 3, and EXT_OPS needs ALU_W=3");
  end

  state_t state, state_nx, dstate;
  logic   aluop;
  logic   branch;
  logic   unmapped;

  alu_decoder #(
    .ALU_W  (ALU_W),
    .EXT_OPS(EXT_OPS)
  ) u_alu_decoder (
    .aluop     (aluop),
    .funct     (Funct[4:0]),
    .alucontrol(ALUControl),
    .flagw     (FlagW),
    .nowrite   (NoWrite),
    .unmapped  (unmapped)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:  state_nx = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  state_nx = MEMADR;
          OP_DP:   state_nx = unmapped ? FETCH : (Funct[5] ? EXECUTEI : EXECUTER);
          OP_BR:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      MEMADR:   state_nx = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_nx = MEMWB;
      EXECUTER: state_nx = ALUWB;
      EXECUTEI: state_nx = ALUWB;
      default:  state_nx = FETCH;
    endcase
  end

  // Holding reset presents the FETCH outputs immediately, even before the first edge
  assign dstate = reset ? FETCH : state;

  // ALU decode stays live through ALUWB so NoWrite/FlagW are stable for the writeback
  assign aluop = (dstate == EXECUTER) || (dstate == EXECUTEI) || (dstate == ALUWB);

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    branch    = 1'b0;
    Undef     = 1'b0;
    case (dstate)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        Undef     = (Op == 2'b11) || ((Op == OP_DP) && unmapped);
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTEI: ALUSrcB = 2'b01;
      ALUWB:    RegW    = ~NoWrite;
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ImmSrc = reset ? 2'b00 : Op;
  assign RegSrc = reset ? 2'b00 : {Op == OP_MEM, Op == OP_BR};
  assign PCS    = ((Rd == 4'hF) && RegW) || branch;

endmodule

// File: tb/tb_mc_decoder.sv
// Randomised bench for mc_decoder: an instruction-level model predicts every
// output on every cycle of each instruction, for both extended and base ALU sets.
module tb_mc_decoder;

  typedef struct packed {
    logic       irw, npc, regw, memw, adrsrc;
    logic [1:0] res, srca, srcb, imm, regsrc;
    logic [2:0] alu;
    logic [1:0] flagw;
    logic       pcs, nowr, undef;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] op1 = 2'b11, op2 = 2'b11;
  logic [5:0] funct1 = '0, funct2 = '0;
  logic [3:0] rd1 = '0, rd2 = '0;

  logic       irw1, npc1, regw1, memw1, adr1, pcs1, nowr1, und1;
  logic [1:0] res1, sa1, sb1, imm1, rs1, fw1;
  logic [2:0] alu1;
  logic       irw2, npc2, regw2, memw2, adr2, pcs2, nowr2, und2;
  logic [1:0] res2, sa2, sb2, imm2, rs2, fw2;
  logic [1:0] alu2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_decoder #(.ALU_W(3), .EXT_OPS(1)) dut_ext (
    .clk(clk), .reset(reset), .Op(op1), .Funct(funct1), .Rd(rd1),
    .IRWrite(irw1), .NextPC(npc1), .RegW(regw1), .MemW(memw1), .AdrSrc(adr1),
    .ResultSrc(res1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ImmSrc(imm1), .RegSrc(rs1),
    .ALUControl(alu1), .FlagW(fw1), .PCS(pcs1), .NoWrite(nowr1), .Undef(und1)
  );

  mc_decoder #(.ALU_W(2), .EXT_OPS(0)) dut_base (
    .clk(clk), .reset(reset), .Op(op2), .Funct(funct2), .Rd(rd2),
    .IRWrite(irw2), .NextPC(npc2), .RegW(regw2), .MemW(memw2), .AdrSrc(adr2),
    .ResultSrc(res2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ImmSrc(imm2), .RegSrc(rs2),
    .ALUControl(alu2), .FlagW(fw2), .PCS(pcs2), .NoWrite(nowr2), .Undef(und2)
  );

  outs_t o1, o2;
  assign o1 = {irw1, npc1, regw1, memw1, adr1, res1, sa1, sb1, imm1, rs1,
               alu1, fw1, pcs1, nowr1, und1};
  assign o2 = {irw2, npc2, regw2, memw2, adr2, res2, sa2, sb2, imm2, rs2,
               1'b0, alu2, fw2, pcs2, nowr2, und2};

  task automatic check(input string tag, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction-set view: command table lookup, 1 = defined
  function automatic bit alu_map(input logic [3:0] f, input bit ext,
                                 output logic [2:0] code, output bit cmp);
    bit ok = 1'b1;
    code = 3'd0;
    cmp  = 1'b0;
    case (f)
      4'b0100: code = 3'd0;
      4'b0010: code = 3'd1;
      4'b0000: code = 3'd2;
      4'b1100: code = 3'd3;
      4'b0001: if (ext) code = 3'd4; else ok = 1'b0;
      4'b1101: if (ext) code = 3'd5; else ok = 1'b0;
      4'b1010: if (ext) begin code = 3'd1; cmp = 1'b1; end else ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [5:0] f, input bit ext);
    logic [2:0] code;
    bit cmp;
    case (op)
      2'b01:   return f[0] ? 5 : 4;
      2'b10:   return 3;
      2'b00:   return alu_map(f[4:1], ext, code, cmp) ? 4 : 2;
      default: return 2;
    endcase
  endfunction

  function automatic outs_t fetch_vals();
    outs_t e = '0;
    e.irw = 1'b1; e.npc = 1'b1; e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10;
    return e;
  endfunction

  // Expected outputs on cycle c of an instruction (c=0 is its FETCH cycle)
  function automatic outs_t expv(input int c, input logic [1:0] op, input logic [5:0] f,
                                 input logic [3:0] rd, input bit ext);
    outs_t e = '0;
    logic [2:0] code;
    bit cmp, ok, branch;
    branch = 1'b0;
    ok = alu_map(f[4:1], ext, code, cmp);
    if (c == 0) e = fetch_vals();
    else if (c == 1) begin
      e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10;
      e.undef = (op == 2'b11) || (op == 2'b00 && !ok);
    end else if (op == 2'b01) begin
      if (c == 2) e.srcb = 2'b01;
      else if (c == 3 && f[0]) e.adrsrc = 1'b1;
      else if (c == 3) begin e.adrsrc = 1'b1; e.memw = 1'b1; end
      else begin e.res = 2'b01; e.regw = 1'b1; end
    end else if (op == 2'b10) begin
      e.srca = 2'b10; e.srcb = 2'b01; e.res = 2'b10; branch = 1'b1;
    end else begin
      e.alu      = code;
      e.flagw[1] = f[0] | cmp;
      e.flagw[0] = e.flagw[1] && (code == 3'd0 || code == 3'd1);
      e.nowr     = cmp;
      if (c == 2) e.srcb = f[5] ? 2'b01 : 2'b00;
      else        e.regw = !cmp;
    end
    e.imm    = op;
    e.regsrc = {op == 2'b01, op == 2'b10};
    e.pcs    = (rd == 4'hF && e.regw) || branch;
    return e;
  endfunction

  int n_instr = 0;

  // Entered just after the edge that starts FETCH; returns just after the edge back into FETCH
  task automatic run_instr(input bit sel, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input int abort_at);
    int lat;
    outs_t exp, got;
    if (sel) begin op2 = op; funct2 = f; rd2 = rd; end
    else     begin op1 = op; funct1 = f; rd1 = rd; end
    lat = latency(op, f, !sel);
    for (int c = 0; c < lat; c++) begin
      if (c == abort_at) reset = 1'b1;
      @(negedge clk);
      exp = (c == abort_at) ? fetch_vals() : expv(c, op, f, rd, !sel);
      got = sel ? o2 : o1;
      check($sformatf("%s i%0d op%b f%b c%0d", sel ? "base" : "ext", n_instr, op, f, c), got, exp);
      @(posedge clk);
      #1;
      if (c == abort_at) begin
        reset = 1'b0;
        break;
      end
    end
    n_instr++;
  endtask

  task automatic reset_pulse(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check($sformatf("reset hold %0d", i), o1, fetch_vals());
      check($sformatf("reset hold base %0d", i), o2, fetch_vals());
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic run_random(input bit sel, input int count);
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] rd;
    int ab;
    for (int i = 0; i < count; i++) begin
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      if ($urandom_range(0, 2) == 0 && op == 2'b00) f[4:1] = 4'b1010;
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      ab = ($urandom_range(0, 11) == 0) ? $urandom_range(0, latency(op, f, !sel) - 1) : -1;
      run_instr(sel, op, f, rd, ab);
    end
  endtask

  initial begin
    reset_pulse(2);
    run_instr(0, 2'b00, 6'b001000, 4'd3,  -1);  // ADD register
    run_instr(0, 2'b01, 6'b011001, 4'hF,  -1);  // LDR into PC
    run_instr(0, 2'b00, 6'b110101, 4'd0,  -1);  // CMP immediate
    run_instr(0, 2'b11, 6'b000000, 4'd1,  -1);  // undefined class
    run_instr(0, 2'b00, 6'b001110, 4'd2,  -1);  // unmapped command
    run_instr(0, 2'b01, 6'b011000, 4'd4,  -1);  // STR
    run_instr(0, 2'b10, 6'b100000, 4'd0,  -1);  // B
    run_instr(0, 2'b00, 6'b111011, 4'hF,  -1);  // MOVS imm to PC
    run_instr(0, 2'b00, 6'b000011, 4'd5,  -1);  // EORS register
    run_instr(0, 2'b00, 6'b101001, 4'd6,  -1);  // ADDS imm
    run_instr(0, 2'b01, 6'b011000, 4'd4,   3);  // STR, reset in MEMWRITE
    run_instr(0, 2'b00, 6'b000101, 4'd7,   2);  // SUBS, reset in EXECUTE
    run_instr(0, 2'b00, 6'b000100, 4'd7,  -1);
    run_random(0, 150);

    op1 = 2'b11;
    reset_pulse(1);
    run_instr(1, 2'b00, 6'b000010, 4'd1, -1);   // EOR undefined without extensions
    run_instr(1, 2'b00, 6'b011010, 4'd1, -1);   // MOV undefined
    run_instr(1, 2'b00, 6'b110101, 4'd1, -1);   // CMP undefined
    run_instr(1, 2'b00, 6'b011001, 4'hF, -1);   // ORRS register to PC
    run_instr(1, 2'b00, 6'b101000, 4'd2, -1);   // ADD imm
    run_random(1, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_decoder.md
MC_DECODER -- requirements
Module: mc_decoder

Interface
REQ-001 The block SHALL have parameter ALU_W, default 3, meaning the ALUControl width; legal values are 2 or 3.
REQ-002 The block SHALL have parameter EXT_OPS, default 1, which enables EOR, MOV and CMP decoding (requires ALU_W=3).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, width 1: rising-edge clock.
REQ-005 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have inputs Op[1:0], Funct[5:0] and Rd[3:0]: instruction fields, valid from the DECODE cycle onward.
REQ-007 The block SHALL have outputs IRWrite, NextPC, RegW, MemW and AdrSrc, each width 1: Moore enables and select.
REQ-008 The block SHALL have outputs ResultSrc[1:0], ALUSrcA[1:0] and ALUSrcB[1:0]: datapath multiplexer selects.
REQ-009 The block SHALL have outputs ImmSrc[1:0], RegSrc[1:0], ALUControl[ALU_W-1:0], FlagW[1:0], PCS, NoWrite and Undef, each width 1 unless a width is given.

Function
REQ-010 The FSM SHALL use the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB and BRANCH.
REQ-011 Transitions SHALL be:
- FETCH->DECODE.
- DECODE: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECUTER; Op=00 with Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11 or an undefined DP op->FETCH.
REQ-012 Further transitions SHALL be:
- MEMADR: Funct[0]=1->MEMREAD, else MEMWRITE.
- MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH.
- EXECUTER/EXECUTEI->ALUWB->FETCH; BRANCH->FETCH.
REQ-013 Outputs SHALL decode from the state register only; every output not listed for a state SHALL be 0.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, MemW=1.
REQ-014 The remaining states SHALL drive:
- EXECUTER: ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=~NoWrite.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-015 ImmSrc SHALL equal Op; RegSrc[0] SHALL equal (Op==10) and RegSrc[1] SHALL equal (Op==01); both are combinational in all states.
REQ-016 When ALUOp=1, Funct[4:1] SHALL map as follows: 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3; with EXT_OPS=1, also 0001 EOR=4, 1101 MOV=5, 1010 CMP=SUB with NoWrite=1.
REQ-017 FlagW[1] SHALL equal Funct[0], forced to 1 for CMP; FlagW[0] SHALL equal FlagW[1] AND (ADD or SUB).
REQ-018 When ALUOp=0, ALUControl SHALL be ADD, FlagW SHALL be 00 and NoWrite SHALL be 0.
REQ-019 Undef SHALL be 1 only in DECODE, for Op=11 or an unmapped Funct[4:1]; in that case no RegW, MemW or Branch is issued.
REQ-020 PCS SHALL equal ((Rd==1111) AND RegW) OR Branch.
REQ-021 Latency SHALL be: DP 4 cycles, LDR 5, STR 4, B 3, undefined 2, each counted from the FETCH edge to the next FETCH.
REQ-022 NoWrite, ALUControl and FlagW SHALL remain stable from EXECUTE through ALUWB while Funct is held; the datapath holds Funct via the IR.

Reset
REQ-023 reset=1 sampled at a clk rising edge SHALL force the state to FETCH in any state, mid-instruction included, with no write enable asserted in the following cycle except the FETCH values.
REQ-024 While reset is held, outputs SHALL be the FETCH values of REQ-013, and all other outputs SHALL be 0.
REQ-025 Reset SHALL take priority over every transition.

Structure
REQ-026 Package mc_pkg SHALL hold the state enum, the Op constants (DP=00, MEM=01, BR=10) and the ALU code localparams.
REQ-027 Sub-module alu_decoder SHALL be combinational and parametrised by ALU_W and EXT_OPS, covering REQ-016 to REQ-018.
REQ-028 An elaboration check SHALL reject EXT_OPS=1 with ALU_W=2.

Verification
REQ-029 Scenario: ADD register (Op=00, Funct=001000) -> states F,D,ER,AW; ALUControl=0 in ER; RegW=1 only in AW; FlagW=00.
REQ-030 Scenario: LDR (Op=01, Funct[0]=1, Rd=15) -> F,D,MA,MR,MW; PCS=1 and RegW=1 in MW; AdrSrc=1 in MR.
REQ-031 Scenario: CMP (Op=00, Funct=110101, EXT_OPS=1) -> ALUControl=1, FlagW=11, RegW=0 in ALUWB.
REQ-032 Scenario: Op=11, then Funct[4:1]=0111 -> Undef=1 in DECODE; next state FETCH; MemW=RegW=0 throughout.
REQ-033 Scenario: reset asserted in MEMWRITE -> FETCH on the next edge; MemW never 1 after that edge.
REQ-034 Scenario: EXT_OPS=0 with EOR -> treated as undefined (Undef=1, 2-cycle return to FETCH).
